// File: rtl/popcnt_accum_ctrl.sv
// Job sequencer around a registered popcount stage: streams len words, sums their set bits, returns the total.
// Optional build macro POPCNT_MASK_EN adds in_mask so only bits set in (in_data & in_mask) are counted.
module popcnt_accum_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 7,
    parameter int LEN_WIDTH  = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef POPCNT_MASK_EN
    input  logic [DATA_WIDTH-1:0] in_mask,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_inReady;
    logic                  r_outValid;
    logic [ACC_WIDTH-1:0]  r_outSum;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [CNT_WIDTH-1:0]  r_stage;
    logic                  r_stageValid;

    logic [DATA_WIDTH-1:0] w_word;
    logic [CNT_WIDTH-1:0]  w_count;
    logic [ACC_WIDTH-1:0]  w_accNext;
    logic                  w_accept;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [DATA_WIDTH-1:0] d);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c + CNT_WIDTH'(d[i]);
        end
        return c;
    endfunction

`ifdef POPCNT_MASK_EN
    assign w_word = in_data & in_mask;
`else
    assign w_word = in_data;
`endif

    assign w_count   = popcount(w_word);
    assign w_accept  = in_valid & r_inReady;
    // The stage register lags the handshake by one cycle, so the add happens one cycle after acceptance.
    assign w_accNext = r_stageValid ? (r_acc + {{(ACC_WIDTH-CNT_WIDTH){1'b0}}, r_stage}) : r_acc;

    assign busy      = r_busy;
    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_sum   = r_outSum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_inReady    <= 1'b0;
            r_outValid   <= 1'b0;
            r_outSum     <= '0;
            r_acc        <= '0;
            r_remaining  <= '0;
            r_stage      <= '0;
            r_stageValid <= 1'b0;
        end else begin
            r_acc        <= w_accNext;
            r_stageValid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_remaining <= len;
                            r_inReady   <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            r_outSum   <= '0;
                            r_outValid <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_stage      <= w_count;
                        r_stageValid <= 1'b1;
                        r_remaining  <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_inReady <= 1'b0;
                            r_state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_outSum   <= w_accNext;
                    r_outValid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
